// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo block: default geometry, the
// occupancy-counter width helper and the default data word type.
// Optional feature macro: SYNC_FIFO_ERR_EN (sticky overflow/underflow outputs).
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // The occupancy counter must be able to hold DEPTH itself, so it needs
  // one bit more than the pointers.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [DEF_DATA_W-1:0] data_t;

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer-facing signal bundle for sync_fifo.
// Optional feature macro: SYNC_FIFO_ERR_EN adds the overflow/underflow flags.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
`ifdef SYNC_FIFO_ERR_EN
  logic              overflow;
  logic              underflow;

  modport master (output wr, rd, din, input dout, full, empty, overflow, underflow);
  modport slave  (input wr, rd, din, output dout, full, empty, overflow, underflow);
`else
  modport master (output wr, rd, din, input dout, full, empty);
  modport slave  (input wr, rd, din, output dout, full, empty);
`endif

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W storage for sync_fifo: synchronous write port and a
// registered read port whose output register clears on reset. The array
// itself is deliberately not reset.
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store the write word; a same-cycle read of this slot still sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read data, held whenever no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count and status flags around a
// sync_fifo_mem storage array. A write while full is accepted only when a
// read frees a slot in the same cycle.
// Optional feature macro: SYNC_FIFO_ERR_EN adds sticky overflow/underflow flags.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          wr_req;
  logic          rd_req;
  logic          wr_en;
  logic          rd_en;
  logic          full_q;
  logic          empty_q;

  // Requests count only when they are a clean 1, so X on wr/rd cannot move pointers.
  always_comb begin
    wr_req  = (bus.wr == 1'b1);
    rd_req  = (bus.rd == 1'b1);
    full_q  = (count == CW'(DEPTH));
    empty_q = (count == '0);
    rd_en   = rd_req && !empty_q;
    wr_en   = wr_req && (!full_q || rd_req);
  end

  assign bus.full  = full_q;
  assign bus.empty = empty_q;

  // Advance pointers on accepted transfers and track occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags: dropped write while full, read attempted while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_req && full_q && !rd_req) begin
        overflow_q <= 1'b1;
      end
      if (rd_req && empty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (bus.dout)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and short random checks for sync_fifo at the default 8 x 16 geometry.
// Optional feature macro: SYNC_FIFO_ERR_EN enables checks of the error flags.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  data_t exp_q[$];
  data_t exp_dout = '0;

  sync_fifo_if #(.DATA_W(DATA_W)) bus ();

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 20 ns clock
  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of wr/rd/din, then update the queue model with what the FIFO must accept.
  task automatic applyStimulus(input logic w, input logic r, input data_t d);
    bit m_full  = (exp_q.size() == DEPTH);
    bit m_empty = (exp_q.size() == 0);
    bit r_acc   = r && !m_empty;
    bit w_acc   = w && (!m_full || r);
    bus.wr  = w;
    bus.rd  = r;
    bus.din = d;
    @(posedge clk);
    #1;
    if (r_acc) exp_dout = exp_q.pop_front();
    if (w_acc) exp_q.push_back(d);
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_dout"}, 32'(bus.dout), 32'(exp_dout));
    checkOutput({tag, "_full"}, 32'(bus.full), 32'(exp_q.size() == DEPTH));
    checkOutput({tag, "_empty"}, 32'(bus.empty), 32'(exp_q.size() == 0));
  endtask

  initial begin
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
    bus.din = '0;
    rst     = 1'b1;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_dout", 32'(bus.dout), 32'h0);
    checkOutput("rst_empty", 32'(bus.empty), 32'h1);
    checkOutput("rst_full", 32'(bus.full), 32'h0);
`ifdef SYNC_FIFO_ERR_EN
    checkOutput("rst_ovf", 32'(bus.overflow), 32'h0);
    checkOutput("rst_unf", 32'(bus.underflow), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Fill with 1..16
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, data_t'(i));
      if (i == 1) checkOutput("fill_empty1", 32'(bus.empty), 32'h0);
      if (i == DEPTH - 1) checkOutput("fill_full15", 32'(bus.full), 32'h0);
    end
    checkOutput("fill_full16", 32'(bus.full), 32'h1);

    // Write while full with no read is dropped
    applyStimulus(1'b1, 1'b0, 8'd99);
    checkOutput("ovf_full", 32'(bus.full), 32'h1);
    checkOutput("ovf_dout", 32'(bus.dout), 32'h0);
`ifdef SYNC_FIFO_ERR_EN
    checkOutput("ovf_flag", 32'(bus.overflow), 32'h1);
`endif

    // Drain: 1..16 in order, no 99
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("drain_dout", 32'(bus.dout), 32'(i));
    end
    checkOutput("drain_empty", 32'(bus.empty), 32'h1);

    // Read while empty for 3 cycles: dout holds 16
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("unf_dout", 32'(bus.dout), 32'd16);
      checkOutput("unf_empty", 32'(bus.empty), 32'h1);
    end
`ifdef SYNC_FIFO_ERR_EN
    checkOutput("unf_flag", 32'(bus.underflow), 32'h1);
`endif
    // Pointers unmoved: a single write then read returns that word
    applyStimulus(1'b1, 1'b0, 8'h55);
    checkOutput("unf_after_empty", 32'(bus.empty), 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("unf_after_dout", 32'(bus.dout), 32'h55);
    checkOutput("unf_after_empty2", 32'(bus.empty), 32'h1);

    // Simultaneous read/write with 5 entries stored
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, data_t'(8'h10 + i));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, data_t'(8'h20 + i));
      checkOutput("sim_dout", 32'(bus.dout), (i < 5) ? 32'(8'h10 + i) : 32'(8'h20 + i - 5));
      checkOutput("sim_empty", 32'(bus.empty), 32'h0);
      checkOutput("sim_full", 32'(bus.full), 32'h0);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("sim_drain", 32'(bus.dout), 32'(8'h25 + i));
    end
    checkOutput("sim_drain_empty", 32'(bus.empty), 32'h1);

    // wr & rd while empty: write only, dout holds 0x29
    applyStimulus(1'b1, 1'b1, 8'd7);
    checkOutput("ewr_dout", 32'(bus.dout), 32'h29);
    checkOutput("ewr_empty", 32'(bus.empty), 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("ewr_read", 32'(bus.dout), 32'd7);
    checkOutput("ewr_empty2", 32'(bus.empty), 32'h1);

    // wr & rd while full: oldest out, new word stored, still full
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, data_t'(8'h30 + i));
    checkOutput("fwr_full_pre", 32'(bus.full), 32'h1);
    applyStimulus(1'b1, 1'b1, 8'hAA);
    checkOutput("fwr_dout", 32'(bus.dout), 32'h30);
    checkOutput("fwr_full", 32'(bus.full), 32'h1);
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("fwr_drain", 32'(bus.dout), (i < DEPTH) ? 32'(8'h30 + i) : 32'hAA);
    end
    checkOutput("fwr_empty", 32'(bus.empty), 32'h1);

    // Asynchronous reset mid-cycle while full
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, data_t'(8'h40 + i));
    checkOutput("arst_full_pre", 32'(bus.full), 32'h1);
    #4;
    rst = 1'b1;
    #1;
    checkOutput("arst_full", 32'(bus.full), 32'h0);
    checkOutput("arst_empty", 32'(bus.empty), 32'h1);
    checkOutput("arst_dout", 32'(bus.dout), 32'h0);
`ifdef SYNC_FIFO_ERR_EN
    checkOutput("arst_ovf", 32'(bus.overflow), 32'h0);
    checkOutput("arst_unf", 32'(bus.underflow), 32'h0);
`endif
    exp_q.delete();
    exp_dout = '0;
    @(negedge clk);
    rst = 1'b0;

    // Random traffic against the queue model
    for (int i = 0; i < 30; i++) begin
      logic w;
      logic r;
      w = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 5);
      applyStimulus(w, r, data_t'($urandom_range(0, 255)));
      checkModel("rnd");
    end
    while (exp_q.size() != 0) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkModel("rnd_drain");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
